// File: rtl/dtcm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dtcm_arbiter
//  Description : Two-port arbiter and access sequencer for the single-port
//                data TCM (1024x32, byte write enables, 1-cycle read).
//                The core port has fixed priority over the external port,
//                except when the external port has been refused MAX_WAIT
//                cycles in a row. The core side gets store lane steering,
//                load extraction with sign/zero extension, and
//                misalignment detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module dtcm_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // core load/store port
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [1:0]  core_size,
    input  logic        core_uns,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_err,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    // external port
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [3:0]  ext_be,
    input  logic [31:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    // TCM macro
    output logic [31:0] tcm_addr,
    output logic [3:0]  tcm_wen,
    output logic [31:0] tcm_wdata,
    input  logic [31:0] tcm_rdata
);

    localparam int unsigned   CNT_W      = 4;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [1:0]    SIZE_BYTE  = 2'd0;
    localparam logic [1:0]    SIZE_HALF  = 2'd1;
    localparam logic          OWNER_CORE = 1'b0;
    localparam logic          OWNER_EXT  = 1'b1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic [1:0]       lane_q, lane_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [31:0]      addr_hold_q, addr_hold_d;

    logic             ext_pri;
    logic             core_mis;
    logic [3:0]       core_wen_steer;
    logic [31:0]      core_wdata_steer;
    logic [31:0]      rd_shifted;
    logic [31:0]      core_rdata_ext;

    // Word address within the TCM ignores the byte-lane bits of the ext port.
    logic             unused_ext_lsb;
    assign unused_ext_lsb = ^ext_addr[1:0];

    // Same-cycle grant: core wins unless the ext port has waited long enough.
    // Grants are held off while reset is asserted so every output reads 0.
    assign ext_pri  = (wait_cnt_q == WAIT_LIMIT);
    assign core_gnt = rst_n & core_req & ~(ext_req & ext_pri);
    assign ext_gnt  = rst_n & ext_req & ~(core_req & ~ext_pri);

    // Misalignment: half needs a[0]=0, word (and reserved size) needs a[1:0]=0.
    always_comb begin
        core_mis = 1'b0;
        case (core_size)
            SIZE_BYTE: core_mis = 1'b0;
            SIZE_HALF: core_mis = core_addr[0];
            default:   core_mis = (core_addr[1:0] != 2'b00);
        endcase
    end
    assign core_err = core_gnt & core_mis;

    // Core store lane steering: replicate the LSB-justified data across lanes.
    always_comb begin
        core_wen_steer   = 4'b1111;
        core_wdata_steer = core_wdata;
        case (core_size)
            SIZE_BYTE: begin
                core_wen_steer   = 4'b0001 << core_addr[1:0];
                core_wdata_steer = {4{core_wdata[7:0]}};
            end
            SIZE_HALF: begin
                core_wen_steer   = core_addr[1] ? 4'b1100 : 4'b0011;
                core_wdata_steer = {2{core_wdata[15:0]}};
            end
            default: begin
                core_wen_steer   = 4'b1111;
                core_wdata_steer = core_wdata;
            end
        endcase
    end

    // TCM drive mux; the address holds its last granted value when idle.
    always_comb begin
        tcm_addr  = addr_hold_q;
        tcm_wen   = 4'b0000;
        tcm_wdata = 32'h0;
        if (core_gnt) begin
            tcm_addr  = {core_addr[31:2], 2'b00};
            tcm_wdata = core_wdata_steer;
            tcm_wen   = (core_we && !core_mis) ? core_wen_steer : 4'b0000;
        end else if (ext_gnt) begin
            tcm_addr  = {ext_addr[31:2], 2'b00};
            tcm_wdata = ext_wdata;
            tcm_wen   = ext_we ? ext_be : 4'b0000;
        end
        addr_hold_d = tcm_addr;
    end

    // Next-state for the read pipeline and the starvation counter.
    always_comb begin
        rd_pend_d  = (core_gnt && !core_we && !core_mis) || (ext_gnt && !ext_we);
        rd_owner_d = rd_owner_q;
        lane_d     = lane_q;
        size_d     = size_q;
        uns_d      = uns_q;
        if (rd_pend_d) begin
            rd_owner_d = core_gnt ? OWNER_CORE : OWNER_EXT;
            lane_d     = core_addr[1:0];
            size_d     = core_size;
            uns_d      = core_uns;
        end

        wait_cnt_d = wait_cnt_q;
        if (!ext_req || ext_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // State registers; an asserted reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= OWNER_CORE;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_hold_q <= 32'h0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    assign core_rvalid = rd_pend_q & (rd_owner_q == OWNER_CORE);
    assign ext_rvalid  = rd_pend_q & (rd_owner_q == OWNER_EXT);

    // Load extraction: shift the addressed lane down, then extend by size.
    assign rd_shifted = tcm_rdata >> {lane_q, 3'b000};
    always_comb begin
        core_rdata_ext = tcm_rdata;
        case (size_q)
            SIZE_BYTE: core_rdata_ext = uns_q ? {24'h0, rd_shifted[7:0]}
                                              : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            SIZE_HALF: core_rdata_ext = uns_q ? {16'h0, rd_shifted[15:0]}
                                              : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default:   core_rdata_ext = tcm_rdata;
        endcase
    end

    assign core_rdata = core_rvalid ? core_rdata_ext : 32'h0;
    assign ext_rdata  = ext_rvalid ? tcm_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dtcm_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dtcm_arbiter
//  Description : Directed self-checking bench for dtcm_arbiter with a
//                behavioural 1024x32 TCM (byte enables, registered read).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dtcm_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we, core_uns;
    logic [31:0] core_addr, core_wdata;
    logic [1:0]  core_size;
    logic        core_gnt, core_err, core_rvalid;
    logic [31:0] core_rdata;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic [3:0]  ext_be;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic [31:0] tcm_addr, tcm_wdata, tcm_rdata;
    logic [3:0]  tcm_wen;

    int checks;
    int errors;

    logic [31:0] mem [0:1023];

    dtcm_arbiter #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_size  (core_size),
        .core_uns   (core_uns),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_err   (core_err),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_be     (ext_be),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .tcm_addr   (tcm_addr),
        .tcm_wen    (tcm_wen),
        .tcm_wdata  (tcm_wdata),
        .tcm_rdata  (tcm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TCM: byte-enabled write, registered read of the old word.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        tcm_rdata = 32'h0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (tcm_wen[b]) mem[tcm_addr[11:2]][b*8 +: 8] <= tcm_wdata[b*8 +: 8];
        tcm_rdata <= mem[tcm_addr[11:2]];
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 0; core_size = 0;
        core_uns = 0; core_wdata = 0;
        ext_req = 0; ext_we = 0; ext_addr = 0; ext_be = 0; ext_wdata = 0;
    endtask

    task automatic core_op(input logic we, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] wd);
        core_req = 1; core_we = we; core_addr = a; core_size = sz;
        core_uns = uns; core_wdata = wd;
    endtask

    task automatic ext_op(input logic we, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
        ext_req = 1; ext_we = we; ext_addr = a; ext_be = be; ext_wdata = wd;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        core_req = 1; ext_req = 1;
        #3;
        checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL reset_core_gnt: got %b expected 0", core_gnt); end
        checks++; if (ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_ext_gnt: got %b expected 0", ext_gnt); end
        checks++; if ({core_rvalid, ext_rvalid, core_err} !== 3'b000) begin errors++; $display("FAIL reset_valids: got %b expected 000", {core_rvalid, ext_rvalid, core_err}); end
        checks++; if (core_rdata !== 32'h0 || ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", core_rdata, ext_rdata); end
        checks++; if (tcm_wen !== 4'h0 || tcm_addr !== 32'h0 || tcm_wdata !== 32'h0) begin errors++; $display("FAIL reset_tcm: got wen %h addr %h wdata %h expected all 0", tcm_wen, tcm_addr, tcm_wdata); end
        idle();
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_byte();
        core_op(1, 32'h103, 2'd0, 0, 32'h000000A5);
        #3;
        checks++; if (core_gnt !== 1'b1 || core_err !== 1'b0) begin errors++; $display("FAIL sb_gnt: got gnt %b err %b expected 1 0", core_gnt, core_err); end
        checks++; if (tcm_wen !== 4'b1000) begin errors++; $display("FAIL sb_wen: got %b expected 1000", tcm_wen); end
        checks++; if (tcm_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", tcm_wdata); end
        checks++; if (tcm_addr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h expected 00000100", tcm_addr); end
        tick();
        // load signed byte immediately after the store
        idle(); core_op(0, 32'h103, 2'd0, 0, 32'h0);
        #3;
        checks++; if (core_gnt !== 1'b1 || tcm_wen !== 4'b0000) begin errors++; $display("FAIL lb_gnt: got gnt %b wen %b expected 1 0000", core_gnt, tcm_wen); end
        tick();
        idle(); core_op(0, 32'h103, 2'd0, 1, 32'h0);
        checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'hFFFFFFA5) begin errors++; $display("FAIL lb_signed: got v %b data %h expected 1 ffffffa5", core_rvalid, core_rdata); end
        checks++; if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL lb_ext_quiet: got %b expected 0", ext_rvalid); end
        tick();
        idle();
        checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h000000A5) begin errors++; $display("FAIL lb_unsigned: got v %b data %h expected 1 000000a5", core_rvalid, core_rdata); end
        #3;
        checks++; if (tcm_addr !== 32'h100 || tcm_wen !== 4'h0 || tcm_wdata !== 32'h0) begin errors++; $display("FAIL idle_hold: got addr %h wen %h wdata %h expected 100 0 0", tcm_addr, tcm_wen, tcm_wdata); end
        tick();
        checks++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin errors++; $display("FAIL rvalid_once: got v %b data %h expected 0 0", core_rvalid, core_rdata); end
    endtask

    task automatic test_half_ext();
        idle(); ext_op(1, 32'h200, 4'b0011, 32'hDEADBEEF);
        #3;
        checks++; if (ext_gnt !== 1'b1 || tcm_wen !== 4'b0011 || tcm_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ew: got gnt %b wen %b wdata %h expected 1 0011 deadbeef", ext_gnt, tcm_wen, tcm_wdata); end
        tick();
        idle(); core_op(1, 32'h202, 2'd1, 0, 32'h00001234);
        #3;
        checks++; if (tcm_wen !== 4'b1100 || tcm_wdata !== 32'h12341234) begin errors++; $display("FAIL sh: got wen %b wdata %h expected 1100 12341234", tcm_wen, tcm_wdata); end
        tick();
        idle(); ext_op(0, 32'h200, 4'b1111, 32'h0);
        #3;
        checks++; if (ext_gnt !== 1'b1 || tcm_wen !== 4'b0000) begin errors++; $display("FAIL er_gnt: got gnt %b wen %b expected 1 0000", ext_gnt, tcm_wen); end
        tick();
        idle(); core_op(0, 32'h202, 2'd1, 0, 32'h0);
        checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1234BEEF) begin errors++; $display("FAIL er_data: got v %b data %h expected 1 1234beef", ext_rvalid, ext_rdata); end
        checks++; if (core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin errors++; $display("FAIL er_core_quiet: got v %b data %h expected 0 0", core_rvalid, core_rdata); end
        tick();
        idle(); core_op(0, 32'h200, 2'd1, 0, 32'h0);
        checks++; if (core_rdata !== 32'h00001234) begin errors++; $display("FAIL lh_hi: got %h expected 00001234", core_rdata); end
        tick();
        idle();
        checks++; if (core_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_lo_signed: got %h expected ffffbeef", core_rdata); end
        tick();
    endtask

    task automatic test_misaligned();
        idle(); core_op(0, 32'h001, 2'd1, 0, 32'h0);
        #3;
        checks++; if ({core_gnt, core_err, tcm_wen} !== 6'b11_0000) begin errors++; $display("FAIL mis_half: got gnt %b err %b wen %b expected 1 1 0000", core_gnt, core_err, tcm_wen); end
        tick();
        idle(); core_op(0, 32'h002, 2'd2, 0, 32'h0);
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL mis_half_rvalid: got %b expected 0", core_rvalid); end
        #3;
        checks++; if ({core_gnt, core_err, tcm_wen} !== 6'b11_0000) begin errors++; $display("FAIL mis_word: got gnt %b err %b wen %b expected 1 1 0000", core_gnt, core_err, tcm_wen); end
        tick();
        idle(); core_op(1, 32'h202, 2'd2, 0, 32'hCAFEF00D);
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL mis_word_rvalid: got %b expected 0", core_rvalid); end
        #3;
        checks++; if (core_err !== 1'b1 || tcm_wen !== 4'b0000) begin errors++; $display("FAIL mis_store: got err %b wen %b expected 1 0000", core_err, tcm_wen); end
        tick();
        idle(); core_op(0, 32'h200, 2'd2, 0, 32'h0);
        tick();
        idle();
        checks++; if (core_rdata !== 32'h1234BEEF) begin errors++; $display("FAIL mis_store_nowrite: got %h expected 1234beef", core_rdata); end
        tick();
    endtask

    task automatic test_starvation();
        logic prev_ext;
        idle();
        core_op(0, 32'h100, 2'd2, 0, 32'h0);
        ext_op(0, 32'h200, 4'b1111, 32'h0);
        prev_ext = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            checks++; if (ext_gnt !== ((i % 5) == 4) || core_gnt !== ((i % 5) != 4)) begin errors++; $display("FAIL starve_gnt[%0d]: got core %b ext %b expected core %b ext %b", i, core_gnt, ext_gnt, (i % 5) != 4, (i % 5) == 4); end
            prev_ext = ((i % 5) == 4);
            tick();
            if (prev_ext) begin
                checks++; if (ext_rvalid !== 1'b1 || core_rvalid !== 1'b0 || ext_rdata !== 32'h1234BEEF) begin errors++; $display("FAIL starve_ext_rd[%0d]: got ev %b cv %b data %h expected 1 0 1234beef", i, ext_rvalid, core_rvalid, ext_rdata); end
            end else begin
                checks++; if (core_rvalid !== 1'b1 || ext_rvalid !== 1'b0 || core_rdata !== 32'hA5000000) begin errors++; $display("FAIL starve_core_rd[%0d]: got cv %b ev %b data %h expected 1 0 a5000000", i, core_rvalid, ext_rvalid, core_rdata); end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i % 2 == 0) core_op(0, 32'h103, 2'd0, 1, 32'h0);
            else            ext_op(0, 32'h200, 4'b1111, 32'h0);
            #3;
            checks++; if (core_gnt !== (i % 2 == 0) || ext_gnt !== (i % 2 == 1)) begin errors++; $display("FAIL alt_gnt[%0d]: got core %b ext %b", i, core_gnt, ext_gnt); end
            tick();
            idle();
            if (i % 2 == 0) begin
                checks++; if (core_rvalid !== 1'b1 || core_rdata !== 32'h000000A5 || ext_rvalid !== 1'b0 || ext_rdata !== 32'h0) begin errors++; $display("FAIL alt_core[%0d]: got cv %b cd %h ev %b ed %h expected 1 000000a5 0 0", i, core_rvalid, core_rdata, ext_rvalid, ext_rdata); end
            end else begin
                checks++; if (ext_rvalid !== 1'b1 || ext_rdata !== 32'h1234BEEF || core_rvalid !== 1'b0 || core_rdata !== 32'h0) begin errors++; $display("FAIL alt_ext[%0d]: got ev %b ed %h cv %b cd %h expected 1 1234beef 0 0", i, ext_rvalid, ext_rdata, core_rvalid, core_rdata); end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        // build up the starvation counter to 4 while the core keeps winning
        idle();
        core_op(0, 32'h100, 2'd2, 0, 32'h0);
        ext_op(0, 32'h200, 4'b1111, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 0;
        #1;
        checks++; if (core_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_rvalid: got cv %b ev %b expected 0 0", core_rvalid, ext_rvalid); end
        checks++; if ({core_gnt, ext_gnt, core_err} !== 3'b000 || core_rdata !== 32'h0 || ext_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_outs: got gnt %b%b err %b rdata %h/%h expected 0", core_gnt, ext_gnt, core_err, core_rdata, ext_rdata); end
        checks++; if (tcm_wen !== 4'h0 || tcm_addr !== 32'h0 || tcm_wdata !== 32'h0) begin errors++; $display("FAIL rst_mid_tcm: got wen %h addr %h wdata %h expected 0", tcm_wen, tcm_addr, tcm_wdata); end
        tick(); tick();
        rst_n = 1;
        checks++; if (core_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin errors++; $display("FAIL rst_release_rvalid: got cv %b ev %b expected 0 0", core_rvalid, ext_rvalid); end
        // counter restarted at 0: the core must win four more times first
        for (int i = 0; i < 5; i++) begin
            #3;
            checks++; if (ext_gnt !== (i == 4) || core_gnt !== (i != 4)) begin errors++; $display("FAIL rst_cnt_gnt[%0d]: got core %b ext %b", i, core_gnt, ext_gnt); end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 0;
        idle();
        test_reset();
        test_byte();
        test_half_ext();
        test_misaligned();
        test_starvation();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
